// File: rtl/div_pkg.sv
// Shared types and helpers for the restoring shift-subtract divider.
package div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StTrial,
        StStopped
    } state_t;

    // Wide enough to hold the iteration count n itself.
    function automatic int unsigned count_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/divider_sequencer.sv
// Control sequencer for the divider: IDLE/SHIFT/TRIAL/STOPPED FSM plus the
// iteration counter. One quotient bit costs one SHIFT and one TRIAL cycle.
module divider_sequencer
    import div_pkg::*;
#(
    parameter int unsigned n = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic divisor_zero,
    output logic load,
    output logic shift,
    output logic trial,
    output logic ready,
    output logic busy
);

    localparam int unsigned CntW = count_width(n);

    state_t            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load    = 1'b0;
        shift   = 1'b0;
        trial   = 1'b0;
        ready   = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load = 1'b1;
                    if (divisor_zero) begin
                        state_d = StStopped;
                    end else begin
                        state_d = StShift;
                        count_d = CntW'(n);
                    end
                end
            end
            StShift: begin
                shift   = 1'b1;
                busy    = 1'b1;
                count_d = count_q - CntW'(1);
                state_d = StTrial;
            end
            StTrial: begin
                trial   = 1'b1;
                busy    = 1'b1;
                // count was already decremented by the preceding SHIFT
                state_d = (count_q == '0) ? StStopped : StShift;
            end
            StStopped: begin
                ready = 1'b1;
                if (start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: rtl/shift_divider.sv
// Sequential restoring divider: A/Q/M datapath and trial subtractor, driven by
// divider_sequencer. Produces an n-bit quotient and remainder.
module shift_divider
    import div_pkg::*;
#(
    parameter int unsigned n = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         ready,
    output logic         busy,
    output logic         div_by_zero
);

    logic [n:0]   acc_q;
    logic [n-1:0] quo_q;
    logic [n-1:0] dsr_q;
    logic         dbz_q;
    logic [n:0]   diff;
    logic         divisor_zero;
    logic         load;
    logic         shift;
    logic         trial;

    assign divisor_zero = (divisor == '0);

    divider_sequencer #(
        .n (n)
    ) u_sequencer (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .divisor_zero (divisor_zero),
        .load         (load),
        .shift        (shift),
        .trial        (trial),
        .ready        (ready),
        .busy         (busy)
    );

    // Sign bit of diff set means the trial subtraction went negative.
    assign diff = acc_q - {1'b0, dsr_q};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            dbz_q <= 1'b0;
        end else if (load) begin
            if (divisor_zero) begin
                acc_q <= {1'b0, dividend};
                quo_q <= '1;
                dbz_q <= 1'b1;
            end else begin
                acc_q <= '0;
                quo_q <= dividend;
                dsr_q <= divisor;
                dbz_q <= 1'b0;
            end
        end else if (shift) begin
            acc_q <= {acc_q[n-1:0], quo_q[n-1]};
            quo_q <= {quo_q[n-2:0], 1'b0};
        end else if (trial && !diff[n]) begin
            acc_q    <= diff;
            quo_q[0] <= 1'b1;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = acc_q[n-1:0];
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_shift_divider.sv
// Self-checking bench for shift_divider at n=4 and n=8: directed table,
// hand-written corner sequences and a randomized sweep against a reference model.
module tb_shift_divider;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic       start4, rdy4, busy4, dbz4;
    logic [3:0] dd4, ds4, q4, r4;
    logic       start8, rdy8, busy8, dbz8;
    logic [7:0] dd8, ds8, q8, r8;

    shift_divider #(.n(4)) dut4 (
        .clock       (clock),
        .reset       (reset),
        .start       (start4),
        .dividend    (dd4),
        .divisor     (ds4),
        .quotient    (q4),
        .remainder   (r4),
        .ready       (rdy4),
        .busy        (busy4),
        .div_by_zero (dbz4)
    );

    shift_divider #(.n(8)) dut8 (
        .clock       (clock),
        .reset       (reset),
        .start       (start8),
        .dividend    (dd8),
        .divisor     (ds8),
        .quotient    (q8),
        .remainder   (r8),
        .ready       (rdy8),
        .busy        (busy8),
        .div_by_zero (dbz8)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         w;
        logic [7:0] dd;
        logic [7:0] ds;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division, divide-by-zero saturates the quotient.
    function automatic void model(input int w, input logic [7:0] dd, input logic [7:0] ds,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dbz, output int lat);
        logic [7:0] mask;
        int         d;
        int         s;
        mask = (w == 4) ? 8'h0f : 8'hff;
        d    = int'(dd & mask);
        s    = int'(ds & mask);
        if (s == 0) begin
            q = mask; r = 8'(d); dbz = 1'b1; lat = 1;
        end else begin
            q = 8'(d / s); r = 8'(d % s); dbz = 1'b0; lat = 2 * w + 1;
        end
    endfunction

    task automatic set_start(input int w, input logic v);
        if (w == 4) start4 = v; else start8 = v;
    endtask

    // Starts a division from IDLE and waits (bounded) for ready.
    task automatic run(input int w, input logic [7:0] dd, input logic [7:0] ds, input bit toggle,
                       output logic [7:0] q, output logic [7:0] r, output logic dbz,
                       output int lat, output int busy_cycles);
        logic rdy, bsy;
        @(negedge clock);
        if (w == 4) begin
            start4 = 1'b1; dd4 = dd[3:0]; ds4 = ds[3:0];
        end else begin
            start8 = 1'b1; dd8 = dd; ds8 = ds;
        end
        lat = -1;
        busy_cycles = 0;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clock);
            #1;
            rdy = (w == 4) ? rdy4 : rdy8;
            bsy = (w == 4) ? busy4 : busy8;
            if (bsy) busy_cycles++;
            if (rdy) begin
                lat = e;
                break;
            end
            @(negedge clock);
            if (toggle) begin
                if (w == 4) begin
                    start4 = ~start4; dd4 = 4'($urandom); ds4 = 4'($urandom);
                end else begin
                    start8 = ~start8; dd8 = 8'($urandom); ds8 = 8'($urandom);
                end
            end else begin
                set_start(w, 1'b0);
            end
        end
        set_start(w, 1'b0);
        q   = (w == 4) ? {4'b0, q4} : q8;
        r   = (w == 4) ? {4'b0, r4} : r8;
        dbz = (w == 4) ? dbz4 : dbz8;
    endtask

    // Acknowledge a result: one start edge in STOPPED returns to IDLE.
    task automatic ack(input int w);
        @(negedge clock);
        set_start(w, 1'b1);
        @(posedge clock);
        #1;
        check("ack_ready_low", (w == 4) ? rdy4 : rdy8, 0);
        @(negedge clock);
        set_start(w, 1'b0);
    endtask

    logic [7:0] q, r, eq, er;
    logic       dbz, edbz;
    int         lat, elat, bc;

    initial begin
        reset  = 1'b1;
        start4 = 1'b0; dd4 = '0; ds4 = '0;
        start8 = 1'b0; dd8 = '0; ds8 = '0;
        #12;
        check("rst_q4", q4, 0);
        check("rst_r4", r4, 0);
        check("rst_ready4", rdy4, 0);
        check("rst_busy4", busy4, 0);
        check("rst_dbz4", dbz4, 0);
        check("rst_q8", q8, 0);
        @(negedge clock);
        reset = 1'b0;

        // 13/4: latency and busy window
        run(4, 8'd13, 8'd4, 1'b0, q, r, dbz, lat, bc);
        check("d13_4_q", q, 3);
        check("d13_4_r", r, 1);
        check("d13_4_dbz", dbz, 0);
        check("d13_4_lat", lat, 9);
        check("d13_4_busy", bc, 8);
        ack(4);

        vecs.push_back('{4, 8'd15, 8'd1, 8'd15, 8'd0, 1'b0, 9});
        vecs.push_back('{4, 8'd7, 8'd9, 8'd0, 8'd7, 1'b0, 9});
        vecs.push_back('{4, 8'd9, 8'd0, 8'd15, 8'd9, 1'b1, 1});
        vecs.push_back('{4, 8'd6, 8'd3, 8'd2, 8'd0, 1'b0, 9});
        vecs.push_back('{8, 8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 17});
        vecs.push_back('{8, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 17});
        vecs.push_back('{8, 8'd255, 8'd0, 8'd255, 8'd255, 1'b1, 1});
        vecs.push_back('{8, 8'd0, 8'd1, 8'd0, 8'd0, 1'b0, 17});
        foreach (vecs[i]) begin
            run(vecs[i].w, vecs[i].dd, vecs[i].ds, 1'b0, q, r, dbz, lat, bc);
            check($sformatf("vec%0d_q", i), q, vecs[i].q);
            check($sformatf("vec%0d_r", i), r, vecs[i].r);
            check($sformatf("vec%0d_dbz", i), dbz, vecs[i].dbz);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            ack(vecs[i].w);
        end

        // Asynchronous reset while in TRIAL
        @(negedge clock);
        start4 = 1'b1; dd4 = 4'd13; ds4 = 4'd4;
        @(posedge clock);
        @(negedge clock);
        start4 = 1'b0;
        @(posedge clock);
        #1;
        check("mid_busy", busy4, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_q", q4, 0);
        check("mid_rst_r", r4, 0);
        check("mid_rst_busy", busy4, 0);
        check("mid_rst_ready", rdy4, 0);
        check("mid_rst_dbz", dbz4, 0);
        @(negedge clock);
        reset = 1'b0;
        run(4, 8'd10, 8'd3, 1'b0, q, r, dbz, lat, bc);
        check("after_rst_q", q, 3);
        check("after_rst_r", r, 1);
        check("after_rst_lat", lat, 9);
        ack(4);

        // start and operands churn while busy
        run(4, 8'd13, 8'd4, 1'b1, q, r, dbz, lat, bc);
        check("toggle_q", q, 3);
        check("toggle_r", r, 1);
        check("toggle_lat", lat, 9);
        ack(4);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            run(8, a, b, 1'b0, q, r, dbz, lat, bc);
            model(8, a, b, eq, er, edbz, elat);
            check($sformatf("rnd%0d_q", i), q, eq);
            check($sformatf("rnd%0d_r", i), r, er);
            check($sformatf("rnd%0d_dbz", i), dbz, edbz);
            check($sformatf("rnd%0d_lat", i), lat, elat);
            if (b != 0) begin
                check($sformatf("rnd%0d_inv", i), int'(q) * int'(b) + int'(r), int'(a));
                check($sformatf("rnd%0d_rlt", i), (r < b) ? 1 : 0, 1);
            end
            ack(8);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
